// File: rtl/reg_decode_operand_stage_pkg.sv
// Shared selector encodings for the decode->execute operand stage.
package reg_decode_operand_stage_pkg;

   // Operand 1 source selector encodings.
   typedef enum logic [1:0] {
      OP1_X   = 2'd0,
      OP1_RS1 = 2'd1,
      OP1_PC  = 2'd2
   } op1_sel_e;

   // Operand 2 source selector encodings; the four IM* forms all pass the decoded immediate.
   typedef enum logic [2:0] {
      OP2_X   = 3'd0,
      OP2_RS2 = 3'd1,
      OP2_IMI = 3'd2,
      OP2_IMS = 3'd3,
      OP2_IMJ = 3'd4,
      OP2_IMU = 3'd5
   } op2_sel_e;

endpackage

// File: rtl/reg_decode_operand_stage_reg_file_2r1w.sv
// Two-read / one-write architectural register file with hardwired x0 and optional
// same-cycle write-back forwarding onto the combinational read ports.
module reg_file_2r1w #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rd0_addr,
   output logic [XLEN-1:0] rd0_data,
   input  logic [AW-1:0]   rd1_addr,
   output logic [XLEN-1:0] rd1_data,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data
);

   logic [XLEN-1:0] mem_r [NREGS];
   logic            wr_live_s;

   // Writes to x0 are dropped so entry 0 keeps its reset value of zero.
   assign wr_live_s = wr_en && (wr_addr != {AW{1'b0}});

   // Register array: cleared on reset, written on the rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_r[i] <= {XLEN{1'b0}};
         end
      end else if (wr_live_s) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Read port 0: x0 reads zero, optional forward of the in-flight write.
   always_comb begin
      rd0_data = {XLEN{1'b0}};
      if (rd0_addr == {AW{1'b0}}) begin
         rd0_data = {XLEN{1'b0}};
      end else if ((BYPASS != 0) && wr_live_s && (wr_addr == rd0_addr)) begin
         rd0_data = wr_data;
      end else begin
         rd0_data = mem_r[rd0_addr];
      end
   end

   // Read port 1: same rules as read port 0.
   always_comb begin
      rd1_data = {XLEN{1'b0}};
      if (rd1_addr == {AW{1'b0}}) begin
         rd1_data = {XLEN{1'b0}};
      end else if ((BYPASS != 0) && wr_live_s && (wr_addr == rd1_addr)) begin
         rd1_data = wr_data;
      end else begin
         rd1_data = mem_r[rd1_addr];
      end
   end

endmodule

// File: rtl/reg_decode_operand_stage.sv
// Register file plus decode->execute operand register with valid/ready handshake,
// flush, raw store-data capture and refresh of held operands on late write-back.
module reg_decode_operand_stage
   import reg_decode_operand_stage_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic [1:0]      op1_sel,
   input  logic [2:0]      op2_sel,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   input  logic            flush,
   input  logic            write_en,
   input  logic [AW-1:0]   write_addr,
   input  logic [XLEN-1:0] write_value,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] store_data,
   output logic            illegal_sel
);

   logic [XLEN-1:0] rf_rd1_s, rf_rd2_s;
   logic [XLEN-1:0] op1_val_s, op2_val_s;
   logic            op1_ill_s, op2_ill_s, op1_reg_s, op2_reg_s;
   logic            accept_s, hold_s, wb_hit_s, ref1_s, ref2_s, refst_s;

   logic            out_valid_r, illegal_r, rs1_reg_r, rs2_reg_r;
   logic [XLEN-1:0] rs1_data_r, rs2_data_r, store_data_r;
   logic [AW-1:0]   rs1_addr_r, rs2_addr_r;

   reg_file_2r1w #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .BYPASS (BYPASS)
   ) u_rf (
      .clk      (clk),
      .rst      (rst),
      .rd0_addr (rs1_addr),
      .rd0_data (rf_rd1_s),
      .rd1_addr (rs2_addr),
      .rd1_data (rf_rd2_s),
      .wr_en    (write_en),
      .wr_addr  (write_addr),
      .wr_data  (write_value)
   );

   assign in_ready = !out_valid_r || out_ready;
   assign accept_s = in_valid && in_ready && !flush;
   assign hold_s   = out_valid_r && !out_ready;
   assign wb_hit_s = write_en && (write_addr != {AW{1'b0}});
   // Held operands only track write-back if their selector actually took a register.
   assign ref1_s   = hold_s && wb_hit_s && rs1_reg_r && (write_addr == rs1_addr_r);
   assign ref2_s   = hold_s && wb_hit_s && rs2_reg_r && (write_addr == rs2_addr_r);
   // Store data is the raw rs2 value, so it follows rs2 regardless of op2 selector.
   assign refst_s  = hold_s && wb_hit_s && (write_addr == rs2_addr_r);

   // Operand 1 source mux; undefined encodings give zero and flag illegal.
   always_comb begin
      op1_val_s = {XLEN{1'b0}};
      op1_ill_s = 1'b0;
      op1_reg_s = 1'b0;
      case (op1_sel)
         OP1_X:   op1_val_s = {XLEN{1'b0}};
         OP1_RS1: begin
            op1_val_s = rf_rd1_s;
            op1_reg_s = 1'b1;
         end
         OP1_PC:  op1_val_s = pc;
         default: op1_ill_s = 1'b1;
      endcase
   end

   // Operand 2 source mux; undefined encodings give zero and flag illegal.
   always_comb begin
      op2_val_s = {XLEN{1'b0}};
      op2_ill_s = 1'b0;
      op2_reg_s = 1'b0;
      case (op2_sel)
         OP2_X:   op2_val_s = {XLEN{1'b0}};
         OP2_RS2: begin
            op2_val_s = rf_rd2_s;
            op2_reg_s = 1'b1;
         end
         OP2_IMI, OP2_IMS, OP2_IMJ, OP2_IMU: op2_val_s = imm;
         default: op2_ill_s = 1'b1;
      endcase
   end

   // Handshake valid: flush wins, then accept, then drain on out_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
      end else if (flush) begin
         out_valid_r <= 1'b0;
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   // Operand payload: captured on accept, otherwise refreshed by matching write-back while held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs1_data_r   <= {XLEN{1'b0}};
         rs2_data_r   <= {XLEN{1'b0}};
         store_data_r <= {XLEN{1'b0}};
         illegal_r    <= 1'b0;
         rs1_addr_r   <= {AW{1'b0}};
         rs2_addr_r   <= {AW{1'b0}};
         rs1_reg_r    <= 1'b0;
         rs2_reg_r    <= 1'b0;
      end else if (accept_s) begin
         rs1_data_r   <= op1_val_s;
         rs2_data_r   <= op2_val_s;
         store_data_r <= rf_rd2_s;
         illegal_r    <= op1_ill_s || op2_ill_s;
         rs1_addr_r   <= rs1_addr;
         rs2_addr_r   <= rs2_addr;
         rs1_reg_r    <= op1_reg_s;
         rs2_reg_r    <= op2_reg_s;
      end else begin
         if (ref1_s) begin
            rs1_data_r <= write_value;
         end
         if (ref2_s) begin
            rs2_data_r <= write_value;
         end
         if (refst_s) begin
            store_data_r <= write_value;
         end
      end
   end

   assign out_valid   = out_valid_r;
   assign rs1_data    = rs1_data_r;
   assign rs2_data    = rs2_data_r;
   assign store_data  = store_data_r;
   assign illegal_sel = illegal_r;

endmodule
